// File: rtl/ps2_mouse_init_seq.sv
// ps2_mouse_init_seq: brings a PS/2 mouse from power-up to streaming mode
// (reset/BAT/ID, set sample rate, enable reporting), with resend handling,
// timeouts and bounded sequence retries, then forwards stream bytes.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// PWR_WAIT | idle after reset for PWR_CYC cycles before the first command
// SEND     | one-cycle tx_req pulse with tx_payload selected by step
// WAIT_TX  | waiting for the transmit engine to report ack or error
// WAIT_RSP | collecting the response bytes of the current command
// STREAM   | init complete, received bytes forwarded to packet processing
// FAIL     | retries exhausted, waits for restart or reset
module ps2_mouse_init_seq #(
    parameter logic [7:0]  SAMPLE_RATE = 8'd100,
    parameter logic [31:0] PWR_CYC     = 32'd25_000_000,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       restart,
    output logic       tx_req,
    output logic [7:0] tx_payload,
    input  logic       tx_valid,
    input  logic       tx_error,
    input  logic       rx_valid,
    input  logic [7:0] rx_payload,
    output logic       stream_en,
    output logic       pkt_vld,
    output logic [7:0] pkt_byte,
    output logic       init_done,
    output logic       init_fail,
    output logic [2:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_PWR_WAIT = 3'd0,
        S_SEND     = 3'd1,
        S_WAIT_TX  = 3'd2,
        S_WAIT_RSP = 3'd3,
        S_STREAM   = 3'd4,
        S_FAIL     = 3'd5
    } state_t;

    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [1:0]  rsp_idx_q, rsp_idx_d;
    logic [2:0]  retry_q, retry_d;
    logic [2:0]  resend_q, resend_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  payload_q, payload_d;
    logic        init_done_q, init_done_d;
    logic        pkt_vld_q, pkt_vld_d;
    logic [7:0]  pkt_byte_q, pkt_byte_d;

    logic        timeout;
    logic        retry_ev;
    logic        cnt_clr;
    logic [7:0]  rsp_exp;
    logic        rsp_last;

    function automatic logic [7:0] cmd_of(input logic [1:0] s);
        case (s)
            2'd0:    cmd_of = 8'hFF;
            2'd1:    cmd_of = 8'hF3;
            2'd2:    cmd_of = SAMPLE_RATE;
            default: cmd_of = 8'hF4;
        endcase
    endfunction

    // Sequencing: next state, step/response tracking, retries and cycle counter
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        rsp_idx_d   = rsp_idx_q;
        retry_d     = retry_q;
        resend_d    = resend_q;
        init_done_d = init_done_q;
        payload_d   = payload_q;
        cnt_d       = cnt_q;
        cnt_clr     = 1'b0;
        retry_ev    = 1'b0;
        timeout     = (cnt_q == TIMEOUT_CYC - 32'd1);
        rsp_exp     = (rsp_idx_q == 2'd0) ? 8'hFA :
                      (rsp_idx_q == 2'd1) ? 8'hAA : 8'h00;
        // only the reset command has BAT and ID bytes after the ack
        rsp_last    = (step_q == 2'd0) ? (rsp_idx_q == 2'd2) : 1'b1;

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == PWR_CYC - 32'd1) state_d = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_error) begin
                    retry_ev = 1'b1;
                end else if (tx_valid) begin
                    state_d   = S_WAIT_RSP;
                    rsp_idx_d = 2'd0;
                end else if (timeout) begin
                    retry_ev = 1'b1;
                end
            end
            S_WAIT_RSP: begin
                if (rx_valid) begin
                    if (rx_payload == rsp_exp) begin
                        resend_d = 3'd0;
                        if (rsp_last) begin
                            if (step_q == 2'd3) begin
                                state_d = S_STREAM;
                            end else begin
                                step_d  = step_q + 2'd1;
                                state_d = S_SEND;
                            end
                        end else begin
                            rsp_idx_d = rsp_idx_q + 2'd1;
                            cnt_clr   = 1'b1;
                        end
                    end else if (rx_payload == 8'hFE) begin
                        // the fourth consecutive resend request escalates
                        if (resend_q == 3'd3) begin
                            retry_ev = 1'b1;
                        end else begin
                            resend_d = resend_q + 3'd1;
                            state_d  = S_SEND;
                        end
                    end else begin
                        retry_ev = 1'b1;
                    end
                end else if (timeout) begin
                    retry_ev = 1'b1;
                end
            end
            default: ;
        endcase

        if (retry_ev) begin
            resend_d  = 3'd0;
            rsp_idx_d = 2'd0;
            if (retry_q == MAX_R) begin
                state_d = S_FAIL;
            end else begin
                retry_d = retry_q + 3'd1;
                step_d  = 2'd0;
                state_d = S_SEND;
            end
        end

        if (state_d == S_STREAM) init_done_d = 1'b1;

        if (restart) begin
            state_d     = S_SEND;
            step_d      = 2'd0;
            retry_d     = 3'd0;
            resend_d    = 3'd0;
            rsp_idx_d   = 2'd0;
            init_done_d = 1'b0;
        end

        // payload is latched on the way into SEND and held until the next SEND
        if (state_d == S_SEND) payload_d = cmd_of(step_d);

        if ((state_d != state_q) || cnt_clr) begin
            cnt_d = 32'd0;
        end else if (state_q inside {S_PWR_WAIT, S_WAIT_TX, S_WAIT_RSP}) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Stream forwarding: bytes arriving while already in STREAM, one cycle later
    always_comb begin
        pkt_vld_d  = rx_valid & (state_q == S_STREAM);
        pkt_byte_d = pkt_vld_d ? rx_payload : pkt_byte_q;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_PWR_WAIT;
            step_q      <= 2'd0;
            rsp_idx_q   <= 2'd0;
            retry_q     <= 3'd0;
            resend_q    <= 3'd0;
            cnt_q       <= 32'd0;
            payload_q   <= 8'd0;
            init_done_q <= 1'b0;
            pkt_vld_q   <= 1'b0;
            pkt_byte_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rsp_idx_q   <= rsp_idx_d;
            retry_q     <= retry_d;
            resend_q    <= resend_d;
            cnt_q       <= cnt_d;
            payload_q   <= payload_d;
            init_done_q <= init_done_d;
            pkt_vld_q   <= pkt_vld_d;
            pkt_byte_q  <= pkt_byte_d;
        end
    end

    assign tx_req     = (state_q == S_SEND);
    assign tx_payload = payload_q;
    assign stream_en  = (state_q == S_STREAM);
    assign init_fail  = (state_q == S_FAIL);
    assign pkt_vld    = pkt_vld_q;
    assign pkt_byte   = pkt_byte_q;
    assign init_done  = init_done_q;
    assign retry_cnt  = retry_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Testbench for ps2_mouse_init_seq: directed init scenarios plus randomized
// mouse behaviour checked against a command-level model of the sequence.
module tb_ps2_mouse_init_seq;

    localparam int PWR   = 10;
    localparam int TOUT  = 100;
    localparam int MAXR  = 3;
    localparam int M_NORM = 0, M_FE = 1, M_BAD = 2, M_TXERR = 3;

    logic       clk, rstn, restart;
    logic       tx_req, tx_valid, tx_error, rx_valid;
    logic [7:0] tx_payload, rx_payload, pkt_byte;
    logic       stream_en, pkt_vld, init_done, init_fail;
    logic [2:0] retry_cnt, state_o;

    ps2_mouse_init_seq #(
        .SAMPLE_RATE(8'h64),
        .PWR_CYC(32'd10),
        .TIMEOUT_CYC(32'd100),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rstn(rstn), .restart(restart),
        .tx_req(tx_req), .tx_payload(tx_payload),
        .tx_valid(tx_valid), .tx_error(tx_error),
        .rx_valid(rx_valid), .rx_payload(rx_payload),
        .stream_en(stream_en), .pkt_vld(pkt_vld), .pkt_byte(pkt_byte),
        .init_done(init_done), .init_fail(init_fail),
        .retry_cnt(retry_cnt), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // command-level model of the mouse bring-up
    logic [7:0] cmd_tab [4];
    int m_step, m_retry, m_fe;
    bit m_done, m_fail;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached (%0d checks, %0d failures)", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req(input int budget, output int cycles);
        cycles = 0;
        while (tx_req !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (tx_req !== 1'b1) chk("tx_req_wait", {31'd0, tx_req}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_payload = b;
        rx_valid   = 1'b1;
        tick();
        rx_valid   = 1'b0;
        rx_payload = 8'($urandom);
    endtask

    task automatic model_restart;
        m_step = 0; m_retry = 0; m_fe = 0; m_done = 0; m_fail = 0;
    endtask

    task automatic model_retry;
        m_fe = 0;
        if (m_retry == MAXR) m_fail = 1;
        else begin
            m_retry++;
            m_step = 0;
        end
    endtask

    // One mouse transaction; entered on the cycle tx_req is seen
    task automatic issue_cmd(input int mode, input logic [7:0] bad);
        chk("tx_payload", {24'd0, tx_payload}, {24'd0, cmd_tab[m_step]});
        tick();
        chk("tx_req_single", {31'd0, tx_req}, 32'd0);
        idle($urandom_range(0, 2));
        if (mode == M_TXERR) begin
            tx_error = 1'b1;
            tick();
            tx_error = 1'b0;
            model_retry();
            return;
        end
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        idle($urandom_range(0, 2));
        case (mode)
            M_NORM: begin
                send_byte(8'hFA);
                if (m_step == 0) begin
                    idle($urandom_range(0, 2));
                    send_byte(8'hAA);
                    idle($urandom_range(0, 2));
                    send_byte(8'h00);
                end
                m_fe = 0;
                if (m_step == 3) m_done = 1;
                else m_step++;
            end
            M_FE: begin
                send_byte(8'hFE);
                m_fe++;
                if (m_fe == 4) model_retry();
            end
            default: begin
                send_byte(bad);
                model_retry();
            end
        endcase
    endtask

    task automatic run_episode(input bit randomized, input int fixed_mode);
        int c, r, mode, n;
        logic [7:0] b;
        n = 0;
        while (!m_done && !m_fail && n < 60) begin
            wait_req(200, c);
            mode = fixed_mode;
            b = 8'hFC;
            if (randomized) begin
                r = $urandom_range(0, 99);
                mode = (r < 65) ? M_NORM : (r < 80) ? M_FE : (r < 92) ? M_BAD : M_TXERR;
                b = 8'($urandom);
                if (b == 8'hFA || b == 8'hFE) b = 8'hFC;
            end
            issue_cmd(mode, b);
            n++;
        end
    endtask

    task automatic check_end(input string tag);
        bit seen_req;
        chk({tag, "_init_done"}, {31'd0, init_done}, {31'd0, m_done});
        chk({tag, "_stream_en"}, {31'd0, stream_en}, {31'd0, m_done});
        chk({tag, "_init_fail"}, {31'd0, init_fail}, {31'd0, m_fail});
        chk({tag, "_retry_cnt"}, {29'd0, retry_cnt}, 32'(m_retry));
        if (m_fail) begin
            seen_req = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (tx_req) seen_req = 1;
            end
            chk({tag, "_no_req_in_fail"}, {31'd0, seen_req}, 32'd0);
        end
    endtask

    task automatic do_restart;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        model_restart();
        chk("restart_tx_req", {31'd0, tx_req}, 32'd1);
        chk("restart_init_done", {31'd0, init_done}, 32'd0);
        chk("restart_retry_cnt", {29'd0, retry_cnt}, 32'd0);
    endtask

    initial begin
        int c;
        logic [7:0] sb [6];
        cmd_tab[0] = 8'hFF; cmd_tab[1] = 8'hF3; cmd_tab[2] = 8'h64; cmd_tab[3] = 8'hF4;
        rstn = 1'b0; restart = 1'b0; tx_valid = 1'b0; tx_error = 1'b0;
        rx_valid = 1'b0; rx_payload = 8'h00;
        idle(3);

        // reset state
        chk("reset_outputs", {5'd0, tx_req, tx_payload, stream_en, pkt_vld, pkt_byte,
                              init_done, init_fail, retry_cnt, state_o}, 32'd0);

        // nominal init
        rstn = 1'b1;
        wait_req(200, c);
        chk("pwr_wait_cycles", 32'(c), 32'(PWR));
        model_restart();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_req(20, c);
            issue_cmd(M_NORM, 8'h00);
        end
        chk("stream_entry_not_forwarded", {31'd0, pkt_vld}, 32'd0);
        check_end("nominal");

        // streaming bytes then restart
        sb[0] = 8'h08; sb[1] = 8'h05; sb[2] = 8'hFB;
        for (int i = 3; i < 6; i++) sb[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            send_byte(sb[i]);
            chk("pkt_vld", {31'd0, pkt_vld}, 32'd1);
            chk("pkt_byte", {24'd0, pkt_byte}, {24'd0, sb[i]});
            tick();
            chk("pkt_vld_drop", {31'd0, pkt_vld}, 32'd0);
        end
        do_restart();
        chk("restart_payload", {24'd0, tx_payload}, 32'h0000_00FF);

        // resend once on F3
        issue_cmd(M_NORM, 8'h00);
        wait_req(20, c);
        issue_cmd(M_FE, 8'h00);
        run_episode(0, M_NORM);
        check_end("resend");

        // timeout waiting for AA
        do_restart();
        chk("tx_payload", {24'd0, tx_payload}, 32'h0000_00FF);
        tick();
        tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        send_byte(8'hFA);
        wait_req(300, c);
        chk("timeout_cycles", 32'(c), 32'(TOUT));
        chk("timeout_retry_cnt", {29'd0, retry_cnt}, 32'd1);
        m_retry = 1; m_step = 0; m_fe = 0;
        run_episode(0, M_NORM);
        check_end("timeout");

        // FC to every FF exhausts retries
        do_restart();
        run_episode(0, M_BAD);
        check_end("exhaust");

        // randomized episodes
        for (int e = 0; e < 10; e++) begin
            do_restart();
            run_episode(1, M_NORM);
            check_end("random");
        end

        // async reset during WAIT_TX
        do_restart();
        tick();
        #3 rstn = 1'b0;
        #1;
        chk("async_reset_outputs", {5'd0, tx_req, tx_payload, stream_en, pkt_vld, pkt_byte,
                                    init_done, init_fail, retry_cnt, state_o}, 32'd0);
        tick();
        rstn = 1'b1;
        rx_valid = 1'b1; rx_payload = 8'hFA; tx_error = 1'b1;
        tick();
        rx_valid = 1'b0; tx_error = 1'b0;
        wait_req(200, c);
        chk("pwr_wait_after_reset", 32'(c + 1), 32'(PWR));
        chk("payload_after_reset", {24'd0, tx_payload}, 32'h0000_00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_init_seq.md
# ps2_mouse_init_seq

Command sequencer for the PS/2 mouse path. It sits between the top level and the byte-level transmit/receive engines (`tx_req`/`tx_payload`/`tx_valid`/`tx_error` and `rx_valid`/`rx_payload`). After power-up it brings the mouse from reset to streaming mode:

- Reset, then wait for BAT and device ID.
- Set the sample rate.
- Enable data reporting.

It handles device NAK/resend, timeouts and bounded retries. Once the sequence completes, it passes received bytes to packet processing.

## Interface

Parameters:
- `SAMPLE_RATE`, default 8'd100: argument sent after the 0xF3 command.
- `PWR_CYC`, default 32'd25_000_000: idle cycles after reset before the first command.
- `TIMEOUT_CYC`, default 32'd50_000_000: maximum cycles spent waiting in WAIT_TX or WAIT_RSP.
- `MAX_RETRY`, default 3: number of sequence restarts before FAIL. Allowed range 1..7.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rstn` in 1: asynchronous, active-low reset.
- `restart` in 1: one-cycle pulse. Re-runs the sequence from step 0 and clears `retry_cnt`.
- `tx_req` out 1: one-cycle pulse that starts a byte transmit.
- `tx_payload` out 8: byte to transmit. Held stable from the `tx_req` pulse until WAIT_TX exits.
- `tx_valid` in 1: pulse. Byte transmitted and line-acked by the device.
- `tx_error` in 1: pulse. Transmit failed.
- `rx_valid` in 1: pulse. `rx_payload` is valid.
- `rx_payload` in 8: received byte.
- `stream_en` out 1: high in STREAM only.
- `pkt_vld` out 1: equals `rx_valid & stream_en`, registered (1-cycle latency).
- `pkt_byte` out 8: `rx_payload` registered together with `pkt_vld`.
- `init_done` out 1: sticky high after the first entry to STREAM. Cleared only by reset or `restart`.
- `init_fail` out 1: high in FAIL.
- `retry_cnt` out 3: count of restarts so far.
- `state_o` out 3: current state encoding, for debug.

## Operation

States: PWR_WAIT, SEND, WAIT_TX, WAIT_RSP, STREAM, FAIL.

Registers:
- `step` (0..3) selects the command byte:
  - 0 → 0xFF
  - 1 → 0xF3
  - 2 → `SAMPLE_RATE`
  - 3 → 0xF4
- `rsp_idx` (0..2) tracks the expected response byte: 0xFA, then for step 0 only 0xAA, then 0x00.

Reset values: all outputs 0, state PWR_WAIT, `step` 0, `retry_cnt` 0, cycle counter 0.

Transitions:
- **PWR_WAIT**: count to `PWR_CYC − 1`, then go to SEND.
- **SEND**: drive `tx_payload` from `step`, pulse `tx_req`, clear the counter, go to WAIT_TX.
- **WAIT_TX**:
  - `tx_valid` → WAIT_RSP with `rsp_idx` = 0.
  - `tx_error` or timeout → retry event.
- **WAIT_RSP**, on each `rx_valid`:
  - Expected byte: advance `rsp_idx` and clear the counter.
  - Final response of the step:
    - `step` < 3: increment `step`, go to SEND.
    - `step` = 3: go to STREAM.
  - 0xFE (resend): go to SEND with the same `step`. Does not count toward `retry_cnt`. If 4 consecutive 0xFE arrive in the same step, that is a retry event.
  - 0xFC or any other unexpected byte → retry event.
  - Timeout → retry event.
- **Retry event**:
  - If `retry_cnt` = `MAX_RETRY`, go to FAIL.
  - Otherwise increment `retry_cnt`, set `step` to 0, go to SEND. PWR_WAIT is not repeated.
- **STREAM**: forward bytes to `pkt_vld`/`pkt_byte`. No timeout. Remains until `restart` or reset.
- **FAIL**: terminal. Exit only on `restart` or reset.
- **`restart`**: valid in any state. Next state is SEND with `step` 0, `retry_cnt` 0, `init_done` 0.

## Timing

Latencies and handshake rules:
- SEND lasts exactly 1 cycle. `tx_req` is high during the cycle in which the state register holds SEND.
- Only one `tx_req` may be outstanding. A second `tx_req` is never issued before WAIT_TX exits.
- `tx_valid` to SEND (next step) is never sooner than the response byte, because a response is always required.
- `pkt_vld`/`pkt_byte` appear 1 cycle after `rx_valid`.
- `rx_valid` in the same cycle as the STREAM entry transition is not forwarded. That byte belongs to the response.

Timeout:
- Timeout fires when the counter reaches `TIMEOUT_CYC − 1` in WAIT_TX or WAIT_RSP.
- The counter clears on every state entry and on every accepted response byte.

Event priority, highest first:
1. `rstn`
2. `restart`
3. `tx_error`
4. `tx_valid`
5. timeout

Further rules:
- `rx_valid` in any state other than WAIT_RSP or STREAM is ignored.
- `tx_error` outside WAIT_TX is ignored.
- Asserting `rstn` low mid-transfer returns all state and outputs to their reset values in the same cycle (asynchronous).

## Test plan

1. **Nominal init.** Use `PWR_CYC` = 10.
   - Stimulus: mouse model acks every command (`tx_valid`), replies FA,AA,00 to FF and FA to F3, 0x64 and F4.
   - Required: `tx_payload` sequence FF,F3,64,F4; `init_done` = 1; `stream_en` = 1; `retry_cnt` = 0.
2. **Resend.**
   - Stimulus: reply 0xFE once to F3.
   - Required: F3 is re-sent; `retry_cnt` stays 0; init completes.
3. **Timeout.** Use `TIMEOUT_CYC` = 100.
   - Stimulus: withhold the AA after FA.
   - Required: timeout at cycle 100 after the FA; `retry_cnt` = 1; FF is re-sent.
4. **Retry exhaustion.** Use `MAX_RETRY` = 3.
   - Stimulus: reply 0xFC to every FF.
   - Required: FF is sent 4 times; then `init_fail` = 1, `tx_req` stays 0, `retry_cnt` = 3.
5. **Streaming and restart.**
   - Stimulus: in STREAM, send bytes 0x08,0x05,0xFB; then pulse `restart`.
   - Required: `pkt_byte` shows the three bytes, each 1 cycle after its `rx_valid`. After `restart`: `init_done` = 0 and FF is issued.
6. **Async reset mid-transfer.**
   - Stimulus: drop `rstn` during WAIT_TX.
   - Required: all outputs are 0 immediately; after release, PWR_WAIT count restarts.
